// File: rtl/nios2_dbg_sysclk_bridge.sv
// Moves virtual-JTAG update-DR/update-IR events into the clk domain and presents the captured command
// through a valid/ready handshake. Optional pending-command timeout: define NIOS2_DBG_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no command held, waiting for an update-DR edge
// PENDING | command held in jdo/cmd_ir, cmd_valid high until handshake (or timeout)
module nios2_dbg_sysclk_bridge #(
    parameter int DR_WIDTH       = 38,
    parameter int IR_WIDTH       = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [DR_WIDTH-1:0]      sr,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [DR_WIDTH-1:0]      jdo,
    output logic [IR_WIDTH-1:0]      cmd_ir,
    output logic [2**IR_WIDTH-1:0]   take_action,
    output logic [2**IR_WIDTH-1:0]   take_no_action,
    output logic [IR_WIDTH-1:0]      ir_latched,
    output logic                     overrun,
    output logic                     timeout
);
    localparam int NCH   = 2**IR_WIDTH;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    if (DR_WIDTH < 4 || IR_WIDTH < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("nios2_dbg_sysclk_bridge: illegal parameter value");
    end

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_hist_q, uir_hist_q;
    logic [ARM_W-1:0]       arm_q;
    logic                   armed, udr_edge, uir_edge;

    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic [IR_WIDTH-1:0] cmd_ir_q, cmd_ir_d, ir_latched_q, ir_latched_d;
    logic [NCH-1:0]      take_action_q, take_action_d, take_no_action_q, take_no_action_d;
    logic [NCH-1:0]      chan_onehot;
    logic                overrun_q, overrun_d;
    logic                load_cmd, handshake, drop_cmd, to_expired;

    // Edges are masked until history has reloaded from the synchronised level after reset,
    // so a level that stayed high across reset is not mistaken for a new update.
    assign armed    = (arm_q == ARM_DONE);
    assign udr_edge = armed && udr_sync_q[SYNC_STAGES-1] && !udr_hist_q;
    assign uir_edge = armed && uir_sync_q[SYNC_STAGES-1] && !uir_hist_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            udr_sync_q       <= '0;
            uir_sync_q       <= '0;
            udr_hist_q       <= 1'b0;
            uir_hist_q       <= 1'b0;
            arm_q            <= '0;
            jdo_q            <= '0;
            cmd_ir_q         <= '0;
            ir_latched_q     <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            udr_sync_q       <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q       <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_hist_q       <= udr_sync_q[SYNC_STAGES-1];
            uir_hist_q       <= uir_sync_q[SYNC_STAGES-1];
            arm_q            <= armed ? arm_q : arm_q + ARM_W'(1);
            jdo_q            <= jdo_d;
            cmd_ir_q         <= cmd_ir_d;
            ir_latched_q     <= ir_latched_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overrun_q        <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_cmd  = 1'b0;
        handshake = 1'b0;
        drop_cmd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (udr_edge) begin
                    state_d  = PENDING;
                    load_cmd = 1'b1;
                end
            end
            PENDING: begin
                if (cmd_ready) begin
                    handshake = 1'b1;
                    if (udr_edge) load_cmd = 1'b1;
                    else          state_d  = IDLE;
                end else begin
                    drop_cmd = udr_edge;
                    if (to_expired) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign chan_onehot = NCH'(1) << cmd_ir_q;

    always_comb begin
        jdo_d            = jdo_q;
        cmd_ir_d         = cmd_ir_q;
        ir_latched_d     = ir_latched_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        overrun_d        = overrun_q | drop_cmd;
        if (handshake) begin
            if (jdo_q[DR_WIDTH-1]) take_action_d    = chan_onehot;
            else                   take_no_action_d = chan_onehot;
        end
        if (load_cmd) begin
            jdo_d    = sr;
            cmd_ir_d = ir_in;
        end
        if (uir_edge) ir_latched_d = ir_in;
    end

`ifdef NIOS2_DBG_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    assign to_expired = (state_q == PENDING) && !cmd_ready &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (load_cmd)                to_cnt_q <= '0;
            else if (state_q == PENDING) to_cnt_q <= to_cnt_q + TO_W'(1);
            if (to_expired) timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign to_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign cmd_valid      = (state_q == PENDING);
    assign jdo            = jdo_q;
    assign cmd_ir         = cmd_ir_q;
    assign ir_latched     = ir_latched_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overrun        = overrun_q;
endmodule

// File: doc/nios2_dbg_sysclk_bridge.md
NIOS2_DBG_SYSCLK_BRIDGE -- requirements
Module: nios2_dbg_sysclk_bridge

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 38, meaning debug data-register width in bits (min 4).
REQ-002 SHALL have parameter IR_WIDTH, default 2, meaning virtual-JTAG instruction width; action channels = 2**IR_WIDTH.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth for vs_udr/vs_uir (min 2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning pending-command timeout in clk cycles (timeout build only).
REQ-005 SHALL use one clock and a synchronous, active-low reset, with ports: clk input 1 system clock; reset_n input 1 synchronous active-low reset.
REQ-006 SHALL have ports: ir_in input IR_WIDTH instruction from TCK domain; sr input DR_WIDTH shift register, stable while vs_udr high; vs_udr input 1 async update-DR level; vs_uir input 1 async update-IR level.
REQ-007 SHALL have ports: cmd_ready input 1 consumer accept; cmd_valid output 1 command pending; jdo output DR_WIDTH captured data; cmd_ir output IR_WIDTH captured instruction.
REQ-008 SHALL have ports: take_action output 2**IR_WIDTH one-hot action pulse; take_no_action output 2**IR_WIDTH one-hot no-action pulse; ir_latched output IR_WIDTH last updated IR; overrun output 1 sticky dropped-command flag; timeout output 1 sticky expired-command flag.

Function
REQ-009 SHALL pass vs_udr and vs_uir through SYNC_STAGES flops each, plus one history flop, and detect rising edges only.
REQ-010 SHALL, on a vs_uir rising edge, load ir_latched from ir_in on that edge.
REQ-011 SHALL implement states IDLE and PENDING; cmd_valid = (state == PENDING).
REQ-012 SHALL, on a vs_udr rising edge in IDLE, load jdo <= sr and cmd_ir <= ir_in and enter PENDING; cmd_valid high after the (SYNC_STAGES+1)th clk edge counting from the first edge sampling vs_udr high.
REQ-013 SHALL, in PENDING with cmd_ready high, complete the handshake: one-cycle pulse on take_action[cmd_ir] if jdo[DR_WIDTH-1]=1, else on take_no_action[cmd_ir], registered on the handshake edge; return to IDLE.
REQ-014 SHALL hold jdo and cmd_ir unchanged while PENDING without handshake.
REQ-015 SHALL, on a vs_udr edge in PENDING without handshake that cycle, drop the new command, keep the held one, and set overrun.
REQ-016 SHALL, on a vs_udr edge coinciding with a handshake, emit the pulse for the old command and load the new one, remaining in PENDING with no overrun.
REQ-017 SHALL assert at most one bit across take_action and take_no_action in any cycle; all pulses last exactly one cycle.
REQ-018 SHALL clear overrun and timeout only by reset.

Reset
REQ-019 SHALL, on reset_n low at a clk edge, set state IDLE, cmd_valid 0, jdo 0, cmd_ir 0, ir_latched 0, take_action 0, take_no_action 0, overrun 0, timeout 0, all synchroniser and history flops 0, timeout counter 0.
REQ-020 SHALL, on reset mid-PENDING, discard the command with no pulse; a vs_udr level still high after reset SHALL NOT produce an edge until it falls and rises again, because history reloads from the synchronised level in the first post-reset cycles.

Configuration
REQ-021 SHALL, with macro NIOS2_DBG_BRIDGE_TIMEOUT_EN defined, count clk cycles in PENDING and on reaching TIMEOUT_CYCLES without handshake return to IDLE, emit no pulse and set timeout; counter clears on entry to PENDING.
REQ-022 SHALL, without NIOS2_DBG_BRIDGE_TIMEOUT_EN, contain no counter, hold PENDING indefinitely and tie timeout to 0.

Verification
REQ-023 Defaults: sr=38'h20_0000_00AB, ir_in=2, pulse vs_udr, cmd_ready=1 -> cmd_valid at edge 3, jdo=38'h20_0000_00AB, take_action=4'b0100 for one cycle.
REQ-024 sr[37]=0, ir_in=1, cmd_ready=0 for 10 cycles then 1 -> jdo stable over 10 cycles; take_no_action=4'b0010 once; cmd_valid low next cycle.
REQ-025 Command pending with cmd_ready=0, second vs_udr with sr=38'h1 -> jdo keeps first value; overrun=1 until reset.
REQ-026 Second vs_udr edge on the handshake cycle -> first pulse emitted, cmd_valid stays 1, jdo = second sr, overrun=0.
REQ-027 reset_n low 1 cycle while PENDING and vs_udr held high -> all outputs 0, no pulse, no new command until vs_udr toggles.
REQ-028 Timeout build, TIMEOUT_CYCLES=16, cmd_ready=0 -> cmd_valid drops after 16 PENDING cycles, timeout=1, no pulse; non-timeout build -> cmd_valid held 100 cycles.
